// File: rtl/bcd_to_bin_seq_if.sv
// Request/result bundle for the sequential BCD-to-binary converter.
//
// Handshake: the master holds bcd_in stable and raises start while the
// converter is idle; the converter samples both on that edge. busy stays
// high for the whole conversion. done is a one-cycle pulse, and binary_out
// and error are valid from that cycle until the next completion. start is
// ignored while busy or done is high.
interface bcd_to_bin_seq_if #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      binary_out;
  logic                  error;

  modport master (
    output start,
    output bcd_in,
    input  busy,
    input  done,
    input  binary_out,
    input  error
  );

  modport slave (
    input  start,
    input  bcd_in,
    output busy,
    output done,
    output binary_out,
    output error
  );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter using reverse double-dabble.
// A valid request takes BIN_W shift/correct iterations; a request with any
// digit above 9 finishes on the next edge with error set and a zero result.
module bcd_to_bin_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_to_bin_seq_if.slave  bus,
  output logic [1:0]       state_o
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SCR_W = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [SCR_W-1:0]   scratch_q;
  logic [SCR_W-1:0]   scratch_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [BIN_W-1:0]   bin_q;
  logic               err_q;
  logic               bad_digit;
  logic [SCR_W-1:0]   shifted;

  // Flag a request that holds any non-decimal nibble.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // One reverse double-dabble step: shift right, then pull every BCD nibble
  // that reached 8 or more back down by 3 (undoes the halving carry of 10).
  always_comb begin
    shifted   = scratch_q >> 1;
    scratch_d = shifted;
    for (int i = 0; i < DIGITS; i++) begin
      if (shifted[BIN_W + 4*i +: 4] >= 4'd8) begin
        scratch_d[BIN_W + 4*i +: 4] = shifted[BIN_W + 4*i +: 4] - 4'd3;
      end
    end
  end

  // Control FSM with registered busy/done/result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bin_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (bus.start) begin
            if (bad_digit) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              bin_q   <= '0;
              err_q   <= 1'b1;
            end else begin
              state_q   <= CONV;
              busy_q    <= 1'b1;
              scratch_q <= {bus.bcd_in, {BIN_W{1'b0}}};
              cnt_q     <= '0;
            end
          end
        end
        CONV: begin
          scratch_q <= scratch_d;
          cnt_q     <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BIN_W - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bin_q   <= scratch_d[BIN_W-1:0];
            err_q   <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.binary_out = bin_q;
  assign bus.error      = err_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq (DIGITS=3, BIN_W=10).
module tb_bcd_to_bin_seq;

  logic       clk;
  logic       rst_n;
  logic [1:0] state;
  int         n_cmp;
  int         n_fail;

  bcd_to_bin_seq_if #(.DIGITS(3), .BIN_W(10)) bus ();

  bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .state_o (state)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int k);
    logic [11:0] b;
    b[11:8] = 4'(k / 100);
    b[7:4]  = 4'((k / 10) % 10);
    b[3:0]  = 4'(k % 10);
    return b;
  endfunction

  // One request: exp_lat is the number of busy cycles before done.
  task automatic do_conv(input logic [11:0] b, input int exp_bin, input logic exp_err,
                         input int exp_lat);
    bus.bcd_in = b;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    for (int i = 0; i < exp_lat; i++) begin
      check("busy_in_conv", 32'(bus.busy), 32'd1);
      check("no_early_done", 32'(bus.done), 32'd0);
      tick();
    end
    check("done_pulse", 32'(bus.done), 32'd1);
    check("busy_at_done", 32'(bus.busy), 32'd0);
    check("state_done", 32'(state), 32'd2);
    check("binary_out", 32'(bus.binary_out), 32'(exp_bin));
    check("error", 32'(bus.error), 32'(exp_err));
    tick();
    check("done_single", 32'(bus.done), 32'd0);
    check("state_idle", 32'(state), 32'd0);
    check("result_hold", 32'(bus.binary_out), 32'(exp_bin));
  endtask

  initial begin
    int done_cnt;
    int cap;
    int gap;
    bit seen;

    n_cmp      = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    tick();
    tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_bin", 32'(bus.binary_out), 32'd0);
    check("rst_err", 32'(bus.error), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    rst_n = 1'b1;
    tick();

    // Valid directed vectors
    do_conv(12'h999, 999, 1'b0, 10);
    do_conv(12'h000, 0, 1'b0, 10);
    do_conv(12'h081, 81, 1'b0, 10);
    do_conv(12'h100, 100, 1'b0, 10);
    do_conv(12'h509, 509, 1'b0, 10);

    // Invalid digits finish next cycle, never busy
    do_conv(12'h1A3, 0, 1'b1, 0);
    do_conv(12'hF00, 0, 1'b1, 0);
    do_conv(12'h09A, 0, 1'b1, 0);
    // A valid request after an error clears error
    do_conv(12'h042, 42, 1'b0, 10);

    // Input change and start pulse in CONV cycle 3 are ignored
    bus.bcd_in = 12'h456;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    tick();
    tick();
    bus.bcd_in = 12'h999;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    done_cnt   = 0;
    cap        = -1;
    for (int i = 0; i < 14; i++) begin
      if (bus.done) begin
        done_cnt++;
        cap = int'(bus.binary_out);
      end
      tick();
    end
    check("midconv_done_count", 32'(done_cnt), 32'd1);
    check("midconv_result", 32'(cap), 32'd456);

    // Reset in CONV cycle 5 aborts without a done pulse
    bus.bcd_in = 12'h777;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("pre_abort_done", 32'(bus.done), 32'd0);
      tick();
    end
    rst_n = 1'b0;
    tick();
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_bin", 32'(bus.binary_out), 32'd0);
    check("abort_err", 32'(bus.error), 32'd0);
    check("abort_state", 32'(state), 32'd0);
    // Start pending on the first edge with reset released
    rst_n = 1'b1;
    do_conv(12'h012, 12, 1'b0, 10);

    // Sweep all codes with start held high; done every 12 cycles
    bus.bcd_in = to_bcd(0);
    bus.start  = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      seen = 1'b0;
      gap  = 0;
      for (int t = 0; t < 20 && !seen; t++) begin
        tick();
        gap++;
        if (bus.done) seen = 1'b1;
      end
      check("sweep_done_seen", 32'(seen), 32'd1);
      if (seen) begin
        check("sweep_value", 32'(bus.binary_out), 32'(k));
        check("sweep_err", 32'(bus.error), 32'd0);
        if (k > 0) check("sweep_spacing", 32'(gap), 32'd12);
      end
      bus.bcd_in = to_bcd((k + 1) % 1000);
    end
    bus.start = 1'b0;
    tick();
    tick();
    check("final_idle", 32'(state), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_seq.md
BCD_TO_BIN_SEQ -- requirements
Module: bcd_to_bin_seq

Interface
REQ-001 Parameter DIGITS, default 3: number of packed BCD digits at the input.
REQ-002 Parameter BIN_W, default 10: binary result width; SHALL satisfy 2^BIN_W > 10^DIGITS - 1 (10 for DIGITS=3).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset is synchronous and active-low.
REQ-005 start  input  1  request to convert bcd_in; sampled only in IDLE.
REQ-006 bcd_in  input  4*DIGITS  packed BCD, digit 0 in [3:0], most significant digit on top.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  single-cycle pulse marking binary_out/error valid.
REQ-009 binary_out  output  BIN_W  converted value; holds until the next completion.
REQ-010 error  output  1  set when the last request contained a digit > 9; holds until the next completion.

Function
REQ-011 FSM states: IDLE, CONV, DONE; any unused encoding SHALL return to IDLE on the next edge.
REQ-012 IDLE & start & all digits <= 9: load scratch = {bcd_in, BIN_W zeros}, clear the iteration counter, and go to CONV.
REQ-013 IDLE & start & any digit > 9: go to DONE; binary_out = 0 and error = 1 on entry (latency 1 edge).
REQ-014 CONV, each edge: shift scratch right by 1, then subtract 3 from every BCD nibble that is >= 8 after the shift (reverse double-dabble).
REQ-015 CONV runs exactly BIN_W iterations; on the edge that performs the last one, go to DONE, load binary_out with the low BIN_W bits of the result, and clear error.
REQ-016 Valid-path latency: done is high in the cycle following the BIN_W-th edge after the start edge (10 cycles for DIGITS=3).
REQ-017 busy = 1 exactly while the state is CONV; done = 1 exactly while the state is DONE.
REQ-018 DONE lasts one cycle, then returns to IDLE unconditionally; start is ignored in DONE.
REQ-019 start is ignored in CONV; a mid-conversion change on bcd_in SHALL NOT affect the result (input captured at load).
REQ-020 Back-to-back conversions: minimum start-to-start spacing is BIN_W+2 cycles; a start held high is re-accepted on the first IDLE cycle.
REQ-021 The conversion is exact for every valid input 0 .. 10^DIGITS - 1; binary_out never overflows BIN_W.

Reset
REQ-022 rst_n low at an edge forces: state = IDLE, busy = 0, done = 0, binary_out = 0, error = 0, scratch and counter cleared.
REQ-023 rst_n low overrides all other inputs, including mid-CONV; the aborted conversion produces no done pulse.
REQ-024 On the first edge with rst_n high, a pending start is accepted normally.

Verification
REQ-025 bcd_in=12'h999, start pulse -> busy for 10 cycles, then done=1 with binary_out=10'd999 (10'h3E7) and error=0.
REQ-026 bcd_in=12'h000 -> binary_out=0, error=0 after 10 cycles; bcd_in=12'h081 -> binary_out=10'd81; bcd_in=12'h100 -> 10'd100.
REQ-027 bcd_in=12'h1A3, start -> done on the next cycle, error=1, binary_out=0, busy never asserted.
REQ-028 Start 12'h456; in CONV cycle 3, drive bcd_in=12'h999 and pulse start -> result 10'd456 and exactly one done pulse.
REQ-029 Start 12'h777; drop rst_n in CONV cycle 5 -> all outputs 0 next cycle, no done pulse; a following start with 12'h012 returns 10'd12.
REQ-030 Exhaustive sweep of all 1000 valid codes with start held high -> each result matches the decimal value, with done spaced every 12 cycles.
